// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: bypass select codes,
// multi-cycle FSM encodings and the countdown width helper.
package haz_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_WB = 2'd2
  } mc_state_e;

  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the hazard/forwarding unit. With HAZ_WB_BYPASS_EN
// defined it also carries the ID-stage register-file read-through flags.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_regwrite;
  logic                      id_mc_issue;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [REG_AW-1:0]         ex_dst;
  logic                      ex_regwrite;
  logic                      ex_memread;
  logic [REG_AW-1:0]         mem_dst;
  logic                      mem_regwrite;
  logic [REG_AW-1:0]         wb_dst;
  logic                      wb_regwrite;
  logic                      mc_wb_ack;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic                      ex_flush;
  logic                      mc_busy;
  logic                      mc_wb_req;
  logic [REG_AW-1:0]         mc_dst;
`ifdef HAZ_WB_BYPASS_EN
  logic [NUM_SRC-1:0]        id_fwd_wb;
`endif

  modport master (
    output id_src, id_src_used, id_dst, id_regwrite, id_mc_issue,
    output ex_src, ex_dst, ex_regwrite, ex_memread,
    output mem_dst, mem_regwrite, wb_dst, wb_regwrite, mc_wb_ack,
    input  fwd_sel, stall, ex_flush, mc_busy, mc_wb_req, mc_dst
`ifdef HAZ_WB_BYPASS_EN
    , input id_fwd_wb
`endif
  );

  modport slave (
    input  id_src, id_src_used, id_dst, id_regwrite, id_mc_issue,
    input  ex_src, ex_dst, ex_regwrite, ex_memread,
    input  mem_dst, mem_regwrite, wb_dst, wb_regwrite, mc_wb_ack,
    output fwd_sel, stall, ex_flush, mc_busy, mc_wb_req, mc_dst
`ifdef HAZ_WB_BYPASS_EN
    , output id_fwd_wb
`endif
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// One EX-operand bypass select: the younger EX/MEM result always beats MEM/WB.
module fwd_select
  import haz_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic              i_mem_regwrite,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_regwrite && (i_mem_dst != '0) && (i_mem_dst == i_src);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_dst  != '0) && (i_wb_dst  == i_src);

  always_comb begin
    o_sel = FWD_NONE;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, ID hazard detection and the single in-flight multi-cycle
// op handshake. Optional macro HAZ_WB_BYPASS_EN adds WB read-through flags.
module hazard_forward_unit
  import haz_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  bus
);

  localparam int CNT_W = cnt_w(MC_LAT);

  if (MC_LAT < 2) begin : g_lat_chk
    $error("hazard_forward_unit: MC_LAT must be at least 2");
  end

  mc_state_e            r_state;
  mc_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [REG_AW-1:0]    r_mc_dst;
  logic [2*NUM_SRC-1:0] w_fwd_sel;
  logic                 w_load_use;
  logic                 w_mc_raw;
  logic                 w_mc_waw;
  logic                 w_mc_active;
  logic                 w_raw_mask;
  logic                 w_stall;
  logic                 w_issue_ok;
  logic                 w_busy;
  logic                 w_wb_req;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_select #(.REG_AW(REG_AW)) u_fwd (
      .i_src          (bus.ex_src[g*REG_AW +: REG_AW]),
      .i_mem_dst      (bus.mem_dst),
      .i_mem_regwrite (bus.mem_regwrite),
      .i_wb_dst       (bus.wb_dst),
      .i_wb_regwrite  (bus.wb_regwrite),
      .o_sel          (w_fwd_sel[2*g +: 2])
    );
  end

  assign bus.fwd_sel = w_fwd_sel;

  // Source-side comparisons against the loading EX op and the in-flight mc op
  always_comb begin
    w_load_use = 1'b0;
    w_mc_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i]) begin
        if (bus.ex_memread && bus.ex_regwrite && (bus.ex_dst != '0) &&
            (bus.id_src[i*REG_AW +: REG_AW] == bus.ex_dst))
          w_load_use = 1'b1;
        if ((r_mc_dst != '0) && (bus.id_src[i*REG_AW +: REG_AW] == r_mc_dst))
          w_mc_raw = 1'b1;
      end
    end
  end

  assign w_mc_active = (r_state != IDLE);
  assign w_mc_waw    = bus.id_regwrite && (r_mc_dst != '0) && (bus.id_dst == r_mc_dst);

`ifdef HAZ_WB_BYPASS_EN
  // Register file reads through the WB port, so the ack cycle needs no RAW stall
  assign w_raw_mask = (r_state == WAIT_WB) && bus.mc_wb_ack;

  always_comb begin
    bus.id_fwd_wb = '0;
    for (int i = 0; i < NUM_SRC; i++)
      bus.id_fwd_wb[i] = bus.wb_regwrite && (bus.wb_dst != '0) &&
                         (bus.wb_dst == bus.id_src[i*REG_AW +: REG_AW]);
  end
`else
  assign w_raw_mask = 1'b0;
`endif

  assign w_stall = w_load_use |
                   (w_mc_active & ((w_mc_raw & ~w_raw_mask) | w_mc_waw | bus.id_mc_issue));
  assign w_issue_ok = (r_state == IDLE) && bus.id_mc_issue && !w_stall;

  assign bus.stall    = w_stall;
  assign bus.ex_flush = w_stall;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_issue_ok)              w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_W'(1))      w_state_nxt = WAIT_WB;
      WAIT_WB: if (bus.mc_wb_ack)           w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_busy   = (r_state != IDLE);
    w_wb_req = (r_state == WAIT_WB);
  end

  assign bus.mc_busy   = w_busy;
  assign bus.mc_wb_req = w_wb_req;
  assign bus.mc_dst    = r_mc_dst;

  // mc_dst only changes on a new issue, so it stays valid past the ack cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mc_dst <= '0;
    end else if (w_issue_ok) begin
      r_cnt    <= CNT_W'(MC_LAT - 1);
      r_mc_dst <= bus.id_dst;
    end else if (r_state == RUN) begin
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed plus randomized bench for hazard_forward_unit against a
// cycle-count reference model of the forwarding/hazard rules.
module tb_hazard_forward_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int MC_LAT  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: busy flag, destination and the cycle the op was accepted
  bit                m_busy;
  logic [REG_AW-1:0] m_dst;
  int                m_acc;
  int                cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [REG_AW-1:0] slice(input logic [NUM_SRC*REG_AW-1:0] v, input int i);
    return v[i*REG_AW +: REG_AW];
  endfunction

  task automatic clear_inputs();
    bus.id_src       = '0;
    bus.id_src_used  = '0;
    bus.id_dst       = '0;
    bus.id_regwrite  = 1'b0;
    bus.id_mc_issue  = 1'b0;
    bus.ex_src       = '0;
    bus.ex_dst       = '0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.mem_dst      = '0;
    bus.mem_regwrite = 1'b0;
    bus.wb_dst       = '0;
    bus.wb_regwrite  = 1'b0;
    bus.mc_wb_ack    = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.id_src[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      bus.ex_src[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
    end
    bus.id_src_used  = NUM_SRC'($urandom_range(0, 3));
    bus.id_dst       = REG_AW'($urandom_range(0, 7));
    bus.id_regwrite  = 1'($urandom_range(0, 1));
    bus.id_mc_issue  = ($urandom_range(0, 5) == 0);
    bus.ex_dst       = REG_AW'($urandom_range(0, 7));
    bus.ex_regwrite  = 1'($urandom_range(0, 1));
    bus.ex_memread   = 1'($urandom_range(0, 1));
    bus.mem_dst      = REG_AW'($urandom_range(0, 7));
    bus.mem_regwrite = 1'($urandom_range(0, 1));
    bus.wb_dst       = REG_AW'($urandom_range(0, 7));
    bus.wb_regwrite  = 1'($urandom_range(0, 1));
    bus.mc_wb_ack    = ($urandom_range(0, 2) == 0);
  endtask

  // Inputs are already driven just after a negedge; check, advance model, move to next negedge
  task automatic run_cycle();
    logic [2*NUM_SRC-1:0] e_fwd;
    logic [NUM_SRC-1:0]   e_idwb;
    logic [REG_AW-1:0]    s;
    logic lu, raw, waw, stl, req, ackcyc;
    #1;
    req    = m_busy && ((cyc - m_acc) >= MC_LAT);
    ackcyc = req && bus.mc_wb_ack;
    lu = 1'b0;
    raw = 1'b0;
    e_fwd = '0;
    e_idwb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = slice(bus.ex_src, i);
      if (bus.mem_regwrite && bus.mem_dst != 0 && bus.mem_dst == s) e_fwd[2*i +: 2] = 2'b10;
      else if (bus.wb_regwrite && bus.wb_dst != 0 && bus.wb_dst == s) e_fwd[2*i +: 2] = 2'b01;
      s = slice(bus.id_src, i);
      e_idwb[i] = bus.wb_regwrite && bus.wb_dst != 0 && bus.wb_dst == s;
      if (bus.id_src_used[i]) begin
        if (bus.ex_memread && bus.ex_regwrite && bus.ex_dst != 0 && s == bus.ex_dst) lu = 1'b1;
        if (m_dst != 0 && s == m_dst) raw = 1'b1;
      end
    end
`ifdef HAZ_WB_BYPASS_EN
    if (ackcyc) raw = 1'b0;
    check("id_fwd_wb", 32'(bus.id_fwd_wb), 32'(e_idwb));
`endif
    waw = bus.id_regwrite && m_dst != 0 && bus.id_dst == m_dst;
    stl = lu || (m_busy && (raw || waw || bus.id_mc_issue));
    check("fwd_sel",   32'(bus.fwd_sel),   32'(e_fwd));
    check("stall",     32'(bus.stall),     32'(stl));
    check("ex_flush",  32'(bus.ex_flush),  32'(stl));
    check("mc_busy",   32'(bus.mc_busy),   32'(m_busy));
    check("mc_wb_req", 32'(bus.mc_wb_req), 32'(req));
    check("mc_dst",    32'(bus.mc_dst),    32'(m_dst));
    if (!rst_n) begin
      m_busy = 1'b0;
      m_dst  = '0;
    end else if (!m_busy) begin
      if (bus.id_mc_issue && !stl) begin
        m_busy = 1'b1;
        m_dst  = bus.id_dst;
        m_acc  = cyc;
      end
    end else if (ackcyc) begin
      m_busy = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    m_busy = 1'b0;
    m_dst  = '0;
    m_acc  = 0;
    cyc    = 0;
    clear_inputs();
    @(negedge clk);
    run_cycle();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd4;
    bus.id_src[4:0] = 5'd4; bus.id_src_used = 2'b01; bus.id_mc_issue = 1'b1;
    run_cycle();
    check("rst_busy", 32'(bus.mc_busy), 32'd0);
    rst_n = 1'b1;
    clear_inputs();
    run_cycle();

    // Forwarding priority on source 1
    bus.ex_src[9:5] = 5'd5; bus.mem_dst = 5'd5; bus.wb_dst = 5'd5;
    bus.mem_regwrite = 1'b1; bus.wb_regwrite = 1'b1;
    run_cycle();
    check("fwd_mem_pri", 32'(bus.fwd_sel[3:2]), 32'd2);
    bus.mem_regwrite = 1'b0;
    run_cycle();
    check("fwd_wb", 32'(bus.fwd_sel[3:2]), 32'd1);
    bus.mem_dst = '0; bus.wb_dst = '0; bus.mem_regwrite = 1'b1; bus.ex_src[9:5] = '0;
    run_cycle();
    check("fwd_zero", 32'(bus.fwd_sel[3:2]), 32'd0);

    // Load-use
    clear_inputs();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd7;
    bus.id_src[4:0] = 5'd7; bus.id_src_used = 2'b01;
    run_cycle();
    check("load_use", 32'(bus.stall), 32'd1);
    bus.id_src_used = 2'b00;
    run_cycle();
    check("load_use_unused", 32'(bus.stall), 32'd0);

    // Multi-cycle issue, latency and held request
    clear_inputs();
    bus.id_mc_issue = 1'b1; bus.id_dst = 5'd9; bus.id_regwrite = 1'b1;
    run_cycle();
    clear_inputs();
    for (int k = 0; k < MC_LAT; k++) run_cycle();
    check("mc_req_at_lat", 32'(bus.mc_wb_req), 32'd1);
    for (int k = 0; k < 2; k++) run_cycle();
    bus.id_src[4:0] = 5'd9; bus.id_src_used = 2'b01;
    run_cycle();
    check("mc_raw", 32'(bus.stall), 32'd1);
    clear_inputs(); bus.id_regwrite = 1'b1; bus.id_dst = 5'd9;
    run_cycle();
    check("mc_waw", 32'(bus.stall), 32'd1);
    clear_inputs(); bus.id_mc_issue = 1'b1;
    run_cycle();
    check("mc_struct", 32'(bus.stall), 32'd1);
    clear_inputs(); bus.id_src[4:0] = 5'd3; bus.id_src_used = 2'b01;
    run_cycle();
    check("mc_unrelated", 32'(bus.stall), 32'd0);

    // Ack cycle with a dependent reader
    clear_inputs();
    bus.id_src[4:0] = 5'd9; bus.id_src_used = 2'b01; bus.mc_wb_ack = 1'b1;
    bus.wb_regwrite = 1'b1; bus.wb_dst = 5'd9;
    #1;
`ifdef HAZ_WB_BYPASS_EN
    check("ack_stall", 32'(bus.stall), 32'd0);
    check("ack_idfwd", 32'(bus.id_fwd_wb[0]), 32'd1);
`else
    check("ack_stall", 32'(bus.stall), 32'd1);
`endif
    run_cycle();
    clear_inputs();
    run_cycle();
    check("ack_idle", 32'(bus.mc_busy), 32'd0);

    // Reset in the middle of RUN
    bus.id_mc_issue = 1'b1; bus.id_dst = 5'd12;
    run_cycle();
    clear_inputs();
    run_cycle();
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_dst = '0;
    run_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < MC_LAT + 3; k++) run_cycle();

    // Randomized traffic
    for (int k = 0; k < 2500; k++) begin
      rand_inputs();
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
